// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO stream reader and its output buffer.
package fifo_stream_pkg;

    localparam int OCC_W     = 2;
    localparam int BUF_DEPTH = 2;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry registered output buffer, FIFO ordered, with push/pop/flush and
// an occupancy count; the head entry is always the oldest stored beat.
import fifo_stream_pkg::*;

module fifo_stream_skid #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [OCC_W-1:0] occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == OCC_W'(0)) head_d = wdata_i;
                    else                    tail_d = wdata_i;
                    occ_d = occ_q + OCC_W'(1);
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - OCC_W'(1);
                end
                // Simultaneous push and pop keeps the count; the new beat lands behind the survivor.
                2'b11: begin
                    if (occ_q == OCC_W'(1)) begin
                        head_d = wdata_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

    overflow_a: assert property (@(posedge clk) disable iff (!rstn)
        !(push_i && !pop_i && !flush_i && occ_q == OCC_W'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter turning a standard-mode FIFO read port into a valid/ready stream.
// Define FIFO_STREAM_READER_LAST_EN to generate m_last every BURST_LEN beats.
import fifo_stream_pkg::*;

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    if (DATA_WIDTH < 1 || BURST_LEN < 1) begin : g_param_check
        $error("fifo_stream_reader: DATA_WIDTH and BURST_LEN must be >= 1");
    end

    logic             inflight_q, inflight_d;
    logic             pop, push, rd;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   level;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q & ~flush;

    // Issue a read only if the beat it returns is guaranteed a buffer slot.
    always_comb begin
        level    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
        fifo_ren = rstn & ~fifo_empty & ~flush & (level < (OCC_W+1)'(BUF_DEPTH));
    end

    assign rd         = fifo_ren & ~fifo_empty;
    assign inflight_d = rd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) inflight_q <= 1'b0;
        else       inflight_q <= inflight_d;
    end

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam int ENTRY_W = DATA_WIDTH + 1;
    localparam int CNT_W   = (clog2(BURST_LEN) > 0) ? clog2(BURST_LEN) : 1;

    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [ENTRY_W-1:0] wdata, head;

    // Beats leave in push order and flush clears both, so tagging at capture matches pop order.
    always_comb begin
        beat_d = beat_q;
        if (flush) begin
            beat_d = '0;
        end else if (push) begin
            beat_d = (beat_q == CNT_W'(BURST_LEN - 1)) ? '0 : beat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) beat_q <= '0;
        else       beat_q <= beat_d;
    end

    assign wdata  = {beat_q == CNT_W'(BURST_LEN - 1), fifo_rdata};
    assign m_data = head[DATA_WIDTH-1:0];
    assign m_last = head[DATA_WIDTH];
`else
    localparam int ENTRY_W = DATA_WIDTH;

    logic [ENTRY_W-1:0] wdata, head;

    assign wdata  = fifo_rdata;
    assign m_data = head;
    assign m_last = 1'b0;
`endif

    fifo_stream_skid #(
        .WIDTH(ENTRY_W)
    ) u_skid (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(flush),
        .wdata_i(wdata),
        .occ_o  (occ),
        .head_o (head)
    );

endmodule
